// File: rtl/pipe_mem_pkg.sv
// -----------------------------------------------------------------------------
// pipe_mem_pkg
// Shared definitions for the MEM-stage data-memory sequencer:
//   - state_t      : sequencer states IDLE / BUSY / DONE (2-bit encoding)
//   - MERR_*       : codes reported on merr_code
//   - DEFAULT_TIMEOUT, TIMER_W : timeout defaults and timer counter width
//   - is_misaligned(): word-alignment test on the low address bits
// -----------------------------------------------------------------------------
package pipe_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MERR_NONE = 2'd0;
  localparam logic [1:0] MERR_MIS  = 2'd1;
  localparam logic [1:0] MERR_CFL  = 2'd2;
  localparam logic [1:0] MERR_TMO  = 2'd3;

  localparam int DEFAULT_TIMEOUT = 255;

  // Wide enough for the largest legal timeout (65535).
  localparam int TIMER_W = 16;

  // Word accesses only: any nonzero byte offset is misaligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/pipe_dmem_timer.sv
// -----------------------------------------------------------------------------
// pipe_dmem_timer
// Clearable up-counter that flags the last permitted BUSY cycle.
// Ports:
//   clock   in  1  clock, posedge
//   reset   in  1  synchronous active-high reset
//   clr     in  1  synchronous clear (priority over en)
//   en      in  1  count enable
//   expired out 1  count has reached TIMEOUT-1 (combinational from count)
// -----------------------------------------------------------------------------
module pipe_dmem_timer
  import pipe_mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] ZERO = TIMER_W'(0);

  logic [TIMER_W-1:0] r_count;

  // Cycle counter: cleared outside BUSY, advances once per BUSY cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= ZERO;
    end else if (clr) begin
      r_count <= ZERO;
    end else if (en) begin
      r_count <= r_count + ONE;
    end else begin
      r_count <= r_count;
    end
  end

  // The sequencer leaves BUSY on this cycle, so the counter never wraps.
  assign expired = (r_count == LAST);

endmodule

// File: rtl/pipe_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_dmem_ctrl
// MEM-stage sequencer between the EX/MEM register and a variable-latency data
// memory. A load/store freezes the pipeline, runs one req/ack transaction,
// captures load data, then releases the pipeline for one advance (DONE) cycle.
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   mwmem, mm2reg         EX/MEM store / load flags
//   malu, mb              EX/MEM byte address / store data
//   dm_req, dm_we         registered memory request and write enable
//   dm_addr, dm_wdata     registered address and store data
//   dm_ack, dm_rdata      memory completion and load data
//   mstall                pipeline freeze (only combinational output)
//   mmo                   captured load data for MEM/WB
//   mdone                 one-cycle pulse in the DONE cycle
//   merr, merr_code       error pulse and held error code
// -----------------------------------------------------------------------------
module pipe_dmem_ctrl
  import pipe_mem_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          mwmem,
  input  logic          mm2reg,
  input  logic [DW-1:0] malu,
  input  logic [DW-1:0] mb,
  output logic          dm_req,
  output logic          dm_we,
  output logic [DW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic          dm_ack,
  input  logic [DW-1:0] dm_rdata,
  output logic          mstall,
  output logic [DW-1:0] mmo,
  output logic          mdone,
  output logic          merr,
  output logic [1:0]    merr_code
);

  state_t        r_state;
  logic          r_req;
  logic          r_we;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_mmo;
  logic          r_mdone;
  logic          r_merr;
  logic [1:0]    r_merr_code;

  logic          w_acc;
  logic          w_mis;
  logic          w_cfl;
  logic          w_busy;
  logic          w_expired;
  logic          w_stall;

  assign w_acc  = mwmem | mm2reg;
  assign w_mis  = w_acc & is_misaligned(malu[1:0]);
  assign w_cfl  = mwmem & mm2reg;
  assign w_busy = (r_state == ST_BUSY);

  pipe_dmem_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (~w_busy),
    .en      (w_busy),
    .expired (w_expired)
  );

  // Freeze: the accepting IDLE cycle plus every BUSY cycle; DONE lets EX/MEM advance.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc && !w_mis) begin
          w_stall = 1'b1;
        end else begin
          w_stall = 1'b0;
        end
      end
      ST_BUSY: w_stall = 1'b1;
      ST_DONE: w_stall = 1'b0;
      default: w_stall = 1'b0;
    endcase
  end

  // Sequencer FSM with registered request, capture and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= {DW{1'b0}};
      r_wdata     <= {DW{1'b0}};
      r_mmo       <= {DW{1'b0}};
      r_mdone     <= 1'b0;
      r_merr      <= 1'b0;
      r_merr_code <= MERR_NONE;
    end else begin
      // Pulses default low; only the transitions below raise them.
      r_mdone <= 1'b0;
      r_merr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc && w_mis) begin
            // Misaligned (takes precedence over conflict): no request, trap flushes.
            r_merr      <= 1'b1;
            r_merr_code <= MERR_MIS;
          end else if (w_acc) begin
            r_addr  <= malu;
            r_wdata <= mb;
            r_we    <= mwmem;   // store wins on a load+store conflict
            r_req   <= 1'b1;
            r_state <= ST_BUSY;
            if (w_cfl) begin
              r_merr      <= 1'b1;
              r_merr_code <= MERR_CFL;
            end else begin
              r_merr_code <= r_merr_code;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (dm_ack) begin
            // Ack wins over a coincident timeout.
            r_req   <= 1'b0;
            r_mdone <= 1'b1;
            r_state <= ST_DONE;
            if (!r_we) begin
              r_mmo <= dm_rdata;
            end else begin
              r_mmo <= r_mmo;
            end
          end else if (w_expired) begin
            r_req       <= 1'b0;
            r_mdone     <= 1'b1;
            r_merr      <= 1'b1;
            r_merr_code <= MERR_TMO;
            r_state     <= ST_DONE;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        ST_DONE: begin
          // EX/MEM advances at this edge; the finished access is never reissued.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign dm_req    = r_req;
  assign dm_we     = r_we;
  assign dm_addr   = r_addr;
  assign dm_wdata  = r_wdata;
  assign mstall    = w_stall;
  assign mmo       = r_mmo;
  assign mdone     = r_mdone;
  assign merr      = r_merr;
  assign merr_code = r_merr_code;

endmodule

// File: tb/tb_pipe_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_dmem_ctrl
// Directed bench: u_dut uses the default timeout, u_dut_t uses TIMEOUT=4.
// Both share the request inputs; each has its own ack line.
// -----------------------------------------------------------------------------
module tb_pipe_dmem_ctrl;

  logic        clock;
  logic        reset;
  logic        mwmem;
  logic        mm2reg;
  logic [31:0] malu;
  logic [31:0] mb;
  logic        dm_ack;
  logic        t_ack;
  logic [31:0] dm_rdata;

  logic        dm_req, dm_we, mstall, mdone, merr;
  logic [31:0] dm_addr, dm_wdata, mmo;
  logic [1:0]  merr_code;

  logic        t_req, t_we, t_mstall, t_mdone, t_merr;
  logic [31:0] t_addr, t_wdata, t_mmo;
  logic [1:0]  t_merr_code;

  int n_tests = 0;
  int n_fail  = 0;
  bit sel_t   = 1'b0;

  pipe_dmem_ctrl u_dut (
    .clock(clock), .reset(reset), .mwmem(mwmem), .mm2reg(mm2reg),
    .malu(malu), .mb(mb), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .mstall(mstall), .mmo(mmo), .mdone(mdone),
    .merr(merr), .merr_code(merr_code)
  );

  pipe_dmem_ctrl #(.DW(32), .TIMEOUT(4)) u_dut_t (
    .clock(clock), .reset(reset), .mwmem(mwmem), .mm2reg(mm2reg),
    .malu(malu), .mb(mb), .dm_req(t_req), .dm_we(t_we),
    .dm_addr(t_addr), .dm_wdata(t_wdata), .dm_ack(t_ack),
    .dm_rdata(dm_rdata), .mstall(t_mstall), .mmo(t_mmo), .mdone(t_mdone),
    .merr(t_merr), .merr_code(t_merr_code)
  );

  // Views of whichever instance the current access targets.
  logic        s_req, s_we, s_mstall, s_mdone;
  logic [31:0] s_addr, s_wdata;
  assign s_req    = sel_t ? t_req    : dm_req;
  assign s_we     = sel_t ? t_we     : dm_we;
  assign s_mstall = sel_t ? t_mstall : mstall;
  assign s_mdone  = sel_t ? t_mdone  : mdone;
  assign s_addr   = sel_t ? t_addr   : dm_addr;
  assign s_wdata  = sel_t ? t_wdata  : dm_wdata;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    mwmem  = 1'b0;
    mm2reg = 1'b0;
    malu   = 32'h0;
    mb     = 32'h0;
  endtask

  // Present one access and run until mdone (bounded). Returns in the DONE cycle.
  task automatic access(input logic st, input logic ld, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata,
                        input int ack_at, input bit use_t,
                        output int n_stall, output int n_req, output bit done);
    sel_t = use_t;
    mwmem = st; mm2reg = ld; malu = addr; mb = data; dm_rdata = rdata;
    dm_ack = 1'b0; t_ack = 1'b0;
    n_stall = 0; n_req = 0; done = 1'b0;
    #1;
    for (int c = 0; c < 300; c++) begin
      if (s_mstall) n_stall++;
      if (s_req) begin
        n_req++;
        chk("req_we", {31'b0, s_we}, {31'b0, st});
        chk("req_addr", s_addr, addr);
        if (st) chk("req_wdata", s_wdata, data);
        if (n_req == ack_at) begin
          if (use_t) t_ack = 1'b1;
          else       dm_ack = 1'b1;
        end
      end
      tick();
      dm_ack = 1'b0; t_ack = 1'b0;
      if (s_mdone) begin
        done = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'b0, done}, 32'd1);
  endtask

  int  ns, nr;
  bit  dn;

  initial begin
    reset = 1'b1; dm_ack = 1'b0; t_ack = 1'b0; dm_rdata = 32'h0;
    idle_inputs();
    tick();
    chk("rst_req",   {31'b0, dm_req}, 32'd0);
    chk("rst_mstall",{31'b0, mstall}, 32'd0);
    chk("rst_mmo",   mmo, 32'd0);
    chk("rst_code",  {30'b0, merr_code}, 32'd0);
    chk("rst_mdone", {31'b0, mdone}, 32'd0);
    reset = 1'b0;
    tick();

    // Load, ack in first BUSY cycle.
    access(1'b0, 1'b1, 32'h100, 32'h0, 32'hCAFEF00D, 1, 1'b0, ns, nr, dn);
    chk("ld_stall", ns, 32'd2);
    chk("ld_req",   nr, 32'd1);
    chk("ld_done_mstall", {31'b0, mstall}, 32'd0);
    chk("ld_mmo",   mmo, 32'hCAFEF00D);
    chk("ld_merr",  {31'b0, merr}, 32'd0);
    idle_inputs();
    tick();
    chk("ld_mdone_pulse", {31'b0, mdone}, 32'd0);

    // Store, ack after 5 cycles.
    access(1'b1, 1'b0, 32'h40, 32'h12345678, 32'hDEADBEEF, 5, 1'b0, ns, nr, dn);
    chk("st_stall", ns, 32'd6);
    chk("st_req",   nr, 32'd5);
    chk("st_mmo",   mmo, 32'hCAFEF00D);
    idle_inputs();
    tick();

    // Misaligned load.
    mm2reg = 1'b1; malu = 32'h103;
    #1;
    chk("mis_mstall", {31'b0, mstall}, 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("mis_req",   {31'b0, dm_req}, 32'd0);
    chk("mis_merr",  {31'b0, merr}, 32'd1);
    chk("mis_code",  {30'b0, merr_code}, 32'd1);
    chk("mis_mstall2", {31'b0, mstall}, 32'd0);
    tick();
    chk("mis_merr_pulse", {31'b0, merr}, 32'd0);
    chk("mis_code_held",  {30'b0, merr_code}, 32'd1);

    // Load+store conflict proceeds as a store.
    mwmem = 1'b1; mm2reg = 1'b1; malu = 32'h80; mb = 32'hA5A5A5A5;
    tick();
    chk("cfl_merr", {31'b0, merr}, 32'd1);
    chk("cfl_code", {30'b0, merr_code}, 32'd2);
    chk("cfl_we",   {31'b0, dm_we}, 32'd1);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("cfl_mdone", {31'b0, mdone}, 32'd1);
    chk("cfl_mmo",   mmo, 32'hCAFEF00D);
    idle_inputs();
    tick();

    // Back-to-back load then store; second access presented in the DONE cycle.
    access(1'b0, 1'b1, 32'h200, 32'h0, 32'h0BADF00D, 1, 1'b0, ns, nr, dn);
    chk("b2b_ld_req", nr, 32'd1);
    chk("b2b_ld_mmo", mmo, 32'h0BADF00D);
    access(1'b1, 1'b0, 32'h204, 32'h5555AAAA, 32'h99999999, 1, 1'b0, ns, nr, dn);
    chk("b2b_st_req",   nr, 32'd1);
    chk("b2b_st_stall", ns, 32'd2);
    chk("b2b_st_mmo",   mmo, 32'h0BADF00D);
    idle_inputs();
    tick();
    chk("b2b_idle_req", {31'b0, dm_req}, 32'd0);

    // Reset in third BUSY cycle; ack arrives one cycle later.
    mm2reg = 1'b1; malu = 32'h400;
    tick(); tick(); tick();
    chk("rmid_req", {31'b0, dm_req}, 32'd1);
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h77777777;
    chk("rmid_req0",  {31'b0, dm_req}, 32'd0);
    chk("rmid_stall", {31'b0, mstall}, 32'd0);
    chk("rmid_mmo",   mmo, 32'd0);
    chk("rmid_addr",  dm_addr, 32'd0);
    chk("rmid_code",  {30'b0, merr_code}, 32'd0);
    tick();
    dm_ack = 1'b0;
    chk("rmid_mdone", {31'b0, mdone}, 32'd0);
    chk("rmid_mmo2",  mmo, 32'd0);
    chk("rmid_req1",  {31'b0, dm_req}, 32'd0);

    // Timeout on the TIMEOUT=4 instance.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    access(1'b0, 1'b1, 32'h300, 32'h0, 32'h31313131, 0, 1'b1, ns, nr, dn);
    chk("tmo_req",   nr, 32'd4);
    chk("tmo_stall", ns, 32'd5);
    chk("tmo_merr",  {31'b0, t_merr}, 32'd1);
    chk("tmo_code",  {30'b0, t_merr_code}, 32'd3);
    chk("tmo_mmo",   t_mmo, 32'd0);
    chk("tmo_reqlow",{31'b0, t_req}, 32'd0);
    idle_inputs();
    tick();
    chk("tmo_mdone_pulse", {31'b0, t_mdone}, 32'd0);

    // Next access after a timeout is accepted normally.
    access(1'b0, 1'b1, 32'h304, 32'h0, 32'h11112222, 2, 1'b1, ns, nr, dn);
    chk("post_req",  nr, 32'd2);
    chk("post_mmo",  t_mmo, 32'h11112222);
    chk("post_merr", {31'b0, t_merr}, 32'd0);
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
